// File: rtl/lcd_8080_bus_master.sv
// rtl/lcd_8080_bus_master.sv - 8080-style parallel LCD bus master with command FIFO
//
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   cmd_valid/ready   command push handshake (ready = FIFO not full)
//   cmd_rs, cmd_rd    0 = index / 1 = data, 1 = read / 0 = write
//   cmd_data          write data (ignored for reads)
//   rsp_valid/data    one-cycle read-data pulse, data held until next read
//   hw_rst_req        request a controller hard-reset sequence
//   busy, fifo_level  activity flag and FIFO occupancy
//   lcd_*             strobes, bus drive value, tristate enable, bus sample
module lcd_8080_bus_master #(
  parameter int DATA_W      = 16,
  parameter int FIFO_DEPTH  = 8,
  parameter int WR_LOW_CYC  = 2,
  parameter int WR_HIGH_CYC = 2,
  parameter int RD_LOW_CYC  = 4,
  parameter int RD_HIGH_CYC = 3,
  parameter int RST_CYC     = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_rs,
  input  logic                          cmd_rd,
  input  logic [DATA_W-1:0]             cmd_data,
  output logic                          rsp_valid,
  output logic [DATA_W-1:0]             rsp_data,
  input  logic                          hw_rst_req,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          lcd_cs_n,
  output logic                          lcd_rs,
  output logic                          lcd_wr_n,
  output logic                          lcd_rd_n,
  output logic                          lcd_rst_n,
  output logic [DATA_W-1:0]             lcd_data_out,
  output logic                          lcd_data_oe,
  input  logic [DATA_W-1:0]             lcd_data_in
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int EW = DATA_W + 2;
  localparam int CW = 16;

  localparam logic [2:0] S_RST   = 3'd0;
  localparam logic [2:0] S_IDLE  = 3'd1;
  localparam logic [2:0] S_SETUP = 3'd2;
  localparam logic [2:0] S_LOW   = 3'd3;
  localparam logic [2:0] S_HIGH  = 3'd4;

  // FIFO entry layout: {rs, rd, data}
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] count;
  logic [LW-1:0] count_next;
  logic [EW-1:0] head;

  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic          cur_rd;
  logic          rst_pend;

  logic          push;
  logic          pop;
  logic          high_done;
  logic [CW-1:0] low_last;
  logic [CW-1:0] high_last;

  assign push       = cmd_valid & cmd_ready;
  assign head       = mem[rd_ptr];
  assign low_last   = cur_rd ? CW'(RD_LOW_CYC - 1)  : CW'(WR_LOW_CYC - 1);
  assign high_last  = cur_rd ? CW'(RD_HIGH_CYC - 1) : CW'(WR_HIGH_CYC - 1);
  assign high_done  = (state == S_HIGH) && (cnt == high_last);
  // A pending hard reset blocks new pops so the sequence runs between transfers.
  assign pop        = (count != '0) && !rst_pend && ((state == S_IDLE) || high_done);
  assign count_next = count + LW'(push) - LW'(pop);
  assign fifo_level = count;

  // Storage has no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {cmd_rs, cmd_rd, cmd_data};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      cmd_ready <= 1'b1;
      busy      <= 1'b1;
      rst_pend  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count     <= count_next;
      // Registered from the next occupancy so a full FIFO never takes an extra push.
      cmd_ready <= (count_next != LW'(FIFO_DEPTH));
      busy      <= (state != S_IDLE) || (count != '0);
      // The flag is consumed only when IDLE acts on it.
      rst_pend  <= (rst_pend && (state != S_IDLE)) || hw_rst_req;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_RST;
      cnt          <= '0;
      cur_rd       <= 1'b0;
      lcd_rst_n    <= 1'b0;
      lcd_cs_n     <= 1'b1;
      lcd_wr_n     <= 1'b1;
      lcd_rd_n     <= 1'b1;
      lcd_rs       <= 1'b0;
      lcd_data_out <= '0;
      lcd_data_oe  <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_data     <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        S_RST: begin
          if (cnt == CW'(RST_CYC - 1)) begin
            state     <= S_IDLE;
            cnt       <= '0;
            lcd_rst_n <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_IDLE: begin
          if (rst_pend) begin
            state     <= S_RST;
            cnt       <= '0;
            lcd_rst_n <= 1'b0;
          end
        end
        S_SETUP: begin
          state <= S_LOW;
          cnt   <= '0;
          if (cur_rd) lcd_rd_n <= 1'b0;
          else        lcd_wr_n <= 1'b0;
        end
        S_LOW: begin
          if (cnt == low_last) begin
            state    <= S_HIGH;
            cnt      <= '0;
            lcd_wr_n <= 1'b1;
            lcd_rd_n <= 1'b1;
            // Capture on the last LOW edge, while the panel still drives the bus.
            if (cur_rd) begin
              rsp_data  <= lcd_data_in;
              rsp_valid <= 1'b1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_HIGH: begin
          if (cnt == high_last) begin
            if (!pop) begin
              state       <= S_IDLE;
              lcd_cs_n    <= 1'b1;
              lcd_data_oe <= 1'b0;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state       <= S_RST;
          cnt         <= '0;
          lcd_rst_n   <= 1'b0;
          lcd_cs_n    <= 1'b1;
          lcd_wr_n    <= 1'b1;
          lcd_rd_n    <= 1'b1;
          lcd_data_oe <= 1'b0;
        end
      endcase

      // Loading a new entry; from HIGH this keeps cs_n low for back-to-back transfers.
      if (pop) begin
        state       <= S_SETUP;
        cnt         <= '0;
        cur_rd      <= head[DATA_W];
        lcd_rs      <= head[DATA_W+1];
        lcd_cs_n    <= 1'b0;
        lcd_data_oe <= !head[DATA_W];
        if (!head[DATA_W]) lcd_data_out <= head[DATA_W-1:0];
      end
    end
  end

endmodule
